vrf_operand_requester: RTL and testbench
========================================

// Module: vrf_operand_requester
// PURPOSE
// - Initiator side of one lane's VRF bank interface: drives per-bank req/addr/wen/wdata/be/tgt_opqueue into the vector register file.
// - Serialises one read command (start word, length, target operand queue) into one bank read per cycle, word n -> bank (start+n)%NrBanks.
// - Merges a single-word write stream with write priority on bank conflict.
// - Gates reads on an operand-queue credit counter; sits between the lane sequencer and the VRF.
// PARAMETERS
// - NrBanks     8    VRF banks per lane; power of two
// - VAddrWidth  16   width of word index and of addr_o per bank
// - LenWidth    8    width of cmd_len_i, in 64-bit words
// - QueueDepth  4    target operand-queue depth = initial credit count
// PORTS
// - clk_i           in   1                      clock
// - rst_i           in   1                      synchronous, active-high reset
// - cmd_valid_i     in   1                      read command valid
// - cmd_ready_o     out  1                      command accepted when valid&ready
// - cmd_addr_i      in   VAddrWidth             start word index (bank = low bits)
// - cmd_len_i       in   LenWidth               words to read; 0 allowed
// - cmd_opqueue_i   in   opqueue_e              target operand queue
// - opq_pop_i       in   1                      target queue consumed one word (returns a credit)
// - wr_valid_i      in   1                      write request valid
// - wr_ready_o      out  1                      write accepted when valid&ready
// - wr_addr_i       in   VAddrWidth             write word index
// - wr_data_i       in   64                     write data (elen_t)
// - wr_be_i         in   8                      byte enables
// - req_o           out  NrBanks                per-bank request
// - addr_o          out  NrBanks x VAddrWidth   per-bank row = word index >> log2(NrBanks)
// - wen_o           out  NrBanks                per-bank write enable
// - wdata_o         out  NrBanks x 64           per-bank write data
// - be_o            out  NrBanks x 8            per-bank byte enables
// - tgt_opqueue_o   out  NrBanks x opqueue_e    per-bank read target
// - done_o          out  1                      one-cycle pulse: command complete
// BEHAVIOUR
// - Reset (rst_i=1 at clk edge): FSM=IDLE, credits=QueueDepth, all outputs 0 (cmd_ready_o=0 during reset).
// - Bank outputs are registered: request decided in cycle t appears on req_o etc. in cycle t+1.
// - FSM IDLE: cmd_ready_o=1; on accept latch addr/len/opqueue, cnt=0 -> ISSUE (len=0 -> WAIT directly).
// - ISSUE: cmd_ready_o=0; issue read for word cur=cmd_addr+cnt when credits>0 and bank(cur) not taken by write;
//   on issue cnt++, credits--; after word len-1 issued -> WAIT.
// - WAIT: one cycle covering VRF read latency; done_o=1 in the cycle WAIT exits; -> IDLE.
// - Word index arithmetic wraps modulo 2^VAddrWidth; bank = cur[log2(NrBanks)-1:0].
// - Credits: issue and opq_pop_i in same cycle -> unchanged; pop with credits=QueueDepth is ignored (saturate).
// - Write: wr_ready_o=1 every cycle out of reset; accepted write always issued next cycle with wen=1 on bank(wr_addr).
// - Conflict: read and write same bank same cycle -> write wins, read retries next cycle; different banks -> both issue.
// - At most one read and one write bank active per cycle; unused banks req_o=0, wen_o=0, data/be/addr=0.
// - Reset mid-command: command dropped, no done_o, credits restored to QueueDepth.
// CONFIGURATION
// - VRF_REQ_PERF_EN defined: extra outputs stall_credit_cnt_o, stall_conflict_cnt_o (32 b each, saturating,
//   cleared on reset) count ISSUE cycles blocked by zero credits / write conflict respectively.
// - Undefined: ports absent, no counters; functional behaviour identical.
// TESTING
// - NrBanks=8, QueueDepth=4: cmd addr=5 len=4 -> req_o banks 5,6,7,0 on 4 consecutive cycles, rows 0,0,0,1; done_o 1 cycle after last.
// - len=6, no pops -> 4 reads then stall; pulse opq_pop_i once -> exactly one more read (word 4) follows.
// - Read targets bank 6 while write to word 14 (bank 6) -> wen_o[6]=1 that cycle, read on bank 6 next cycle; conflict count=1.
// - Write to bank 2 concurrent with read on bank 3 -> req_o=8'b0000_1100, wen_o=8'b0000_0100 same cycle.
// - cmd len=0 -> no req_o bits ever set, done_o pulses 2 cycles after accept, cmd_ready_o back to 1.
// - Assert rst_i after 2 of 6 reads -> next cycle all outputs 0, no done_o; new cmd runs with full 4 credits.

Source files
------------

// File: rtl/vrf_operand_requester.sv
// vrf_operand_requester: initiator side of one lane's VRF bank interface.
// Turns one read command into one bank read per cycle. Reads are gated by
// operand-queue credits. A single-word write stream is merged in and takes
// priority when it needs the same bank as the pending read.
// Optional feature macro: VRF_REQ_PERF_EN adds saturating stall counters
// (zero-credit stalls and write-conflict stalls).

package vrf_operand_requester_pkg;
    typedef enum logic [1:0] {
        OPQ_ALU_A = 2'd0,
        OPQ_ALU_B = 2'd1,
        OPQ_MFPU  = 2'd2,
        OPQ_STORE = 2'd3
    } opqueue_e;
endpackage

module vrf_operand_requester
    import vrf_operand_requester_pkg::*;
#(
    parameter int unsigned NrBanks    = 8,
    parameter int unsigned VAddrWidth = 16,
    parameter int unsigned LenWidth   = 8,
    parameter int unsigned QueueDepth = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  cmd_valid_i,
    output logic                                  cmd_ready_o,
    input  logic [VAddrWidth-1:0]                 cmd_addr_i,
    input  logic [LenWidth-1:0]                   cmd_len_i,
    input  opqueue_e                              cmd_opqueue_i,
    input  logic                                  opq_pop_i,
    input  logic                                  wr_valid_i,
    output logic                                  wr_ready_o,
    input  logic [VAddrWidth-1:0]                 wr_addr_i,
    input  logic [63:0]                           wr_data_i,
    input  logic [7:0]                            wr_be_i,
    output logic [NrBanks-1:0]                    req_o,
    output logic [NrBanks-1:0][VAddrWidth-1:0]    addr_o,
    output logic [NrBanks-1:0]                    wen_o,
    output logic [NrBanks-1:0][63:0]              wdata_o,
    output logic [NrBanks-1:0][7:0]               be_o,
    output opqueue_e [NrBanks-1:0]                tgt_opqueue_o,
    output logic                                  done_o
`ifdef VRF_REQ_PERF_EN
    ,
    output logic [31:0]                           stall_credit_cnt_o,
    output logic [31:0]                           stall_conflict_cnt_o
`endif
);

    localparam int unsigned BankW = $clog2(NrBanks);
    localparam int unsigned CredW = $clog2(QueueDepth + 1);
    localparam logic [CredW-1:0] CredFull = CredW'(QueueDepth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Latched command
    logic [VAddrWidth-1:0] cmd_addr_q;
    logic [LenWidth-1:0]   cmd_len_q;
    opqueue_e              cmd_opq_q;
    logic [LenWidth-1:0]   cnt_q, cnt_d;

    logic [CredW-1:0]      credits_q, credits_d;

    logic                  cmd_acc;
    logic                  wr_acc;
    logic [VAddrWidth-1:0] cur_word;
    logic [BankW-1:0]      rd_bank;
    logic [BankW-1:0]      wr_bank;
    logic                  conflict;
    logic                  rd_issue;

    // Stage p0: bank request decided this cycle; p1: registered bank outputs
    logic [NrBanks-1:0]                 req_p0, req_p1;
    logic [NrBanks-1:0][VAddrWidth-1:0] addr_p0, addr_p1;
    logic [NrBanks-1:0]                 wen_p0, wen_p1;
    logic [NrBanks-1:0][63:0]           wdata_p0, wdata_p1;
    logic [NrBanks-1:0][7:0]            be_p0, be_p1;
    opqueue_e [NrBanks-1:0]             tgt_p0, tgt_p1;
    logic                               done_p1;

    assign cmd_ready_o = (state_q == IDLE) && !rst_i;
    assign wr_ready_o  = !rst_i;
    assign cmd_acc     = cmd_valid_i && cmd_ready_o;
    assign wr_acc      = wr_valid_i && wr_ready_o;

    // Word index wraps naturally at 2^VAddrWidth
    assign cur_word = cmd_addr_q + VAddrWidth'(cnt_q);
    assign rd_bank  = cur_word[BankW-1:0];
    assign wr_bank  = wr_addr_i[BankW-1:0];
    assign conflict = wr_acc && (wr_bank == rd_bank);
    assign rd_issue = (state_q == ISSUE) && (credits_q != '0) && !conflict;

    // Next-state logic of the command sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    cnt_d   = '0;
                    state_d = (cmd_len_i == '0) ? WAIT : ISSUE;
                end
            end
            ISSUE: begin
                if (rd_issue) begin
                    cnt_d = cnt_q + LenWidth'(1);
                    if (cnt_q == cmd_len_q - LenWidth'(1)) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Credit bookkeeping: an issue and a pop in the same cycle cancel out
    always_comb begin
        credits_d = credits_q;
        if (rd_issue && !opq_pop_i) begin
            credits_d = credits_q - CredW'(1);
        end else if (!rd_issue && opq_pop_i && (credits_q != CredFull)) begin
            credits_d = credits_q + CredW'(1);
        end
    end

    // Per-bank request build: at most one read bank and one write bank
    always_comb begin
        req_p0   = '0;
        addr_p0  = '0;
        wen_p0   = '0;
        wdata_p0 = '0;
        be_p0    = '0;
        for (int b = 0; b < NrBanks; b++) begin
            tgt_p0[b] = OPQ_ALU_A;
        end
        if (rd_issue) begin
            req_p0[rd_bank]  = 1'b1;
            addr_p0[rd_bank] = cur_word >> BankW;
            tgt_p0[rd_bank]  = cmd_opq_q;
        end
        if (wr_acc) begin
            req_p0[wr_bank]   = 1'b1;
            wen_p0[wr_bank]   = 1'b1;
            addr_p0[wr_bank]  = wr_addr_i >> BankW;
            wdata_p0[wr_bank] = wr_data_i;
            be_p0[wr_bank]    = wr_be_i;
        end
    end

    // Control state: FSM, word counter and credits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            credits_q <= CredFull;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            credits_q <= credits_d;
        end
    end

    // Command fields captured on accept
    always_ff @(posedge clk_i) begin
        if (cmd_acc) begin
            cmd_addr_q <= cmd_addr_i;
            cmd_len_q  <= cmd_len_i;
            cmd_opq_q  <= cmd_opqueue_i;
        end
    end

    // Registered bank interface and completion pulse; cleared on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_p1   <= '0;
            addr_p1  <= '0;
            wen_p1   <= '0;
            wdata_p1 <= '0;
            be_p1    <= '0;
            for (int b = 0; b < NrBanks; b++) begin
                tgt_p1[b] <= OPQ_ALU_A;
            end
            done_p1  <= 1'b0;
        end else begin
            req_p1   <= req_p0;
            addr_p1  <= addr_p0;
            wen_p1   <= wen_p0;
            wdata_p1 <= wdata_p0;
            be_p1    <= be_p0;
            tgt_p1   <= tgt_p0;
            done_p1  <= (state_q == WAIT);
        end
    end

    assign req_o         = req_p1;
    assign addr_o        = addr_p1;
    assign wen_o         = wen_p1;
    assign wdata_o       = wdata_p1;
    assign be_o          = be_p1;
    assign tgt_opqueue_o = tgt_p1;
    assign done_o        = done_p1;

`ifdef VRF_REQ_PERF_EN
    logic [31:0] stall_credit_q, stall_conflict_q;

    // Saturating counts of ISSUE cycles that could not issue a read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_credit_q   <= '0;
            stall_conflict_q <= '0;
        end else if (state_q == ISSUE) begin
            if ((credits_q == '0) && (stall_credit_q != '1)) begin
                stall_credit_q <= stall_credit_q + 32'd1;
            end else if ((credits_q != '0) && conflict && (stall_conflict_q != '1)) begin
                stall_conflict_q <= stall_conflict_q + 32'd1;
            end
        end
    end

    assign stall_credit_cnt_o   = stall_credit_q;
    assign stall_conflict_cnt_o = stall_conflict_q;
`endif

endmodule

// File: tb/tb_vrf_operand_requester.sv
// tb_vrf_operand_requester: directed bench for vrf_operand_requester with an
// expected-output scoreboard (NrBanks=8, QueueDepth=4).

module tb_vrf_operand_requester;
    import vrf_operand_requester_pkg::*;

    localparam int NB = 8;
    localparam int VW = 16;
    localparam int LW = 8;
    localparam int QD = 4;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic [VW-1:0]             cmd_addr_i;
    logic [LW-1:0]             cmd_len_i;
    opqueue_e                  cmd_opqueue_i;
    logic                      opq_pop_i;
    logic                      wr_valid_i;
    logic                      wr_ready_o;
    logic [VW-1:0]             wr_addr_i;
    logic [63:0]               wr_data_i;
    logic [7:0]                wr_be_i;
    logic [NB-1:0]             req_o;
    logic [NB-1:0][VW-1:0]     addr_o;
    logic [NB-1:0]             wen_o;
    logic [NB-1:0][63:0]       wdata_o;
    logic [NB-1:0][7:0]        be_o;
    opqueue_e [NB-1:0]         tgt_opqueue_o;
    logic                      done_o;
`ifdef VRF_REQ_PERF_EN
    logic [31:0]               stall_credit_cnt_o;
    logic [31:0]               stall_conflict_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    vrf_operand_requester #(
        .NrBanks   (NB),
        .VAddrWidth(VW),
        .LenWidth  (LW),
        .QueueDepth(QD)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_len_i    (cmd_len_i),
        .cmd_opqueue_i(cmd_opqueue_i),
        .opq_pop_i    (opq_pop_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .wr_be_i      (wr_be_i),
        .req_o        (req_o),
        .addr_o       (addr_o),
        .wen_o        (wen_o),
        .wdata_o      (wdata_o),
        .be_o         (be_o),
        .tgt_opqueue_o(tgt_opqueue_o),
        .done_o       (done_o)
`ifdef VRF_REQ_PERF_EN
        ,
        .stall_credit_cnt_o  (stall_credit_cnt_o),
        .stall_conflict_cnt_o(stall_conflict_cnt_o)
`endif
    );

    typedef struct {
        string       tag;
        logic [7:0]  req;
        logic [7:0]  wen;
        logic        done;
        logic        rdy;
        int          chk_b;
        logic [15:0] row;
        opqueue_e    tgt;
        logic [63:0] wdata;
        logic [7:0]  be;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_empty observed=0 entries expected=1");
            return;
        end
        e = sb.pop_front();
        n_vec++;
        assert (req_o === e.req) else begin
            n_err++;
            $error("FAIL %s req_o observed=%b expected=%b", e.tag, req_o, e.req);
        end
        n_vec++;
        assert (wen_o === e.wen) else begin
            n_err++;
            $error("FAIL %s wen_o observed=%b expected=%b", e.tag, wen_o, e.wen);
        end
        n_vec++;
        assert (done_o === e.done) else begin
            n_err++;
            $error("FAIL %s done_o observed=%b expected=%b", e.tag, done_o, e.done);
        end
        n_vec++;
        assert (cmd_ready_o === e.rdy) else begin
            n_err++;
            $error("FAIL %s cmd_ready_o observed=%b expected=%b", e.tag, cmd_ready_o, e.rdy);
        end
        if (e.chk_b >= 0) begin
            n_vec++;
            assert (addr_o[e.chk_b] === e.row) else begin
                n_err++;
                $error("FAIL %s addr_o[%0d] observed=%h expected=%h", e.tag, e.chk_b,
                       addr_o[e.chk_b], e.row);
            end
            if (e.wen[e.chk_b]) begin
                n_vec++;
                assert (wdata_o[e.chk_b] === e.wdata && be_o[e.chk_b] === e.be) else begin
                    n_err++;
                    $error("FAIL %s wdata/be[%0d] observed=%h/%h expected=%h/%h", e.tag, e.chk_b,
                           wdata_o[e.chk_b], be_o[e.chk_b], e.wdata, e.be);
                end
            end else begin
                n_vec++;
                assert (tgt_opqueue_o[e.chk_b] === e.tgt) else begin
                    n_err++;
                    $error("FAIL %s tgt_opqueue_o[%0d] observed=%0d expected=%0d", e.tag, e.chk_b,
                           tgt_opqueue_o[e.chk_b], e.tgt);
                end
            end
        end
    endtask

    // Push the expected post-edge outputs for the inputs currently driven,
    // advance one clock, then pop and compare.
    task automatic expect_next(input string tag, input logic [7:0] req, input logic [7:0] wen,
                               input logic done, input logic rdy, input int chk_b = -1,
                               input logic [15:0] row = 16'h0, input opqueue_e tgt = OPQ_ALU_A,
                               input logic [63:0] wdata = 64'h0, input logic [7:0] be = 8'h0);
        exp_t e;
        e.tag   = tag;
        e.req   = req;
        e.wen   = wen;
        e.done  = done;
        e.rdy   = rdy;
        e.chk_b = chk_b;
        e.row   = row;
        e.tgt   = tgt;
        e.wdata = wdata;
        e.be    = be;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i         = 1'b1;
        cmd_valid_i   = 1'b0;
        cmd_addr_i    = '0;
        cmd_len_i     = '0;
        cmd_opqueue_i = OPQ_ALU_A;
        opq_pop_i     = 1'b0;
        wr_valid_i    = 1'b0;
        wr_addr_i     = '0;
        wr_data_i     = '0;
        wr_be_i       = '0;

        // Reset state
        repeat (2) expect_next("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        chk1("wr_ready_in_reset", wr_ready_o, 1'b0);
        rst_i = 1'b0;
        expect_next("idle", 8'h00, 8'h00, 1'b0, 1'b1);
        chk1("wr_ready_out_of_reset", wr_ready_o, 1'b1);

        // addr=5 len=4: banks 5,6,7,0, rows 0,0,0,1, done one cycle after last
        cmd_valid_i = 1'b1; cmd_addr_i = 16'd5; cmd_len_i = 8'd4; cmd_opqueue_i = OPQ_ALU_B;
        expect_next("t1_accept", 8'h00, 8'h00, 1'b0, 1'b0);
        cmd_valid_i = 1'b0;
        expect_next("t1_w0", 8'h20, 8'h00, 1'b0, 1'b0, 5, 16'd0, OPQ_ALU_B);
        expect_next("t1_w1", 8'h40, 8'h00, 1'b0, 1'b0, 6, 16'd0, OPQ_ALU_B);
        expect_next("t1_w2", 8'h80, 8'h00, 1'b0, 1'b0, 7, 16'd0, OPQ_ALU_B);
        expect_next("t1_w3", 8'h01, 8'h00, 1'b0, 1'b0, 0, 16'd1, OPQ_ALU_B);
        expect_next("t1_done", 8'h00, 8'h00, 1'b1, 1'b1);
        expect_next("t1_idle", 8'h00, 8'h00, 1'b0, 1'b1);

        // Return all credits plus two surplus pops that must saturate
        opq_pop_i = 1'b1;
        repeat (6) expect_next("refill", 8'h00, 8'h00, 1'b0, 1'b1);
        opq_pop_i = 1'b0;

        // len=6 without pops: 4 reads then stall; one pop releases exactly word 4
        cmd_valid_i = 1'b1; cmd_addr_i = 16'd0; cmd_len_i = 8'd6; cmd_opqueue_i = OPQ_MFPU;
        expect_next("t2_accept", 8'h00, 8'h00, 1'b0, 1'b0);
        cmd_valid_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            expect_next("t2_rd", 8'(1 << b), 8'h00, 1'b0, 1'b0, b, 16'd0, OPQ_MFPU);
        end
        repeat (2) expect_next("t2_stall", 8'h00, 8'h00, 1'b0, 1'b0);
        opq_pop_i = 1'b1;
        expect_next("t2_pop", 8'h00, 8'h00, 1'b0, 1'b0);
        opq_pop_i = 1'b0;
        expect_next("t2_w4", 8'h10, 8'h00, 1'b0, 1'b0, 4, 16'd0, OPQ_MFPU);
        repeat (2) expect_next("t2_stall_again", 8'h00, 8'h00, 1'b0, 1'b0);
        rst_i = 1'b1;
        expect_next("t2_reset", 8'h00, 8'h00, 1'b0, 1'b0);
        rst_i = 1'b0;
        expect_next("t2_after_reset", 8'h00, 8'h00, 1'b0, 1'b1);

        // Read on bank 6 collides with write to word 14 (bank 6): write first
        cmd_valid_i = 1'b1; cmd_addr_i = 16'd6; cmd_len_i = 8'd1; cmd_opqueue_i = OPQ_STORE;
        expect_next("t3_accept", 8'h00, 8'h00, 1'b0, 1'b0);
        cmd_valid_i = 1'b0;
        wr_valid_i = 1'b1; wr_addr_i = 16'd14; wr_data_i = 64'hDEAD_BEEF_0123_4567; wr_be_i = 8'hF0;
        expect_next("t3_write", 8'h40, 8'h40, 1'b0, 1'b0, 6, 16'd1, OPQ_ALU_A,
                    64'hDEAD_BEEF_0123_4567, 8'hF0);
        wr_valid_i = 1'b0;
        expect_next("t3_read", 8'h40, 8'h00, 1'b0, 1'b0, 6, 16'd0, OPQ_STORE);
        expect_next("t3_done", 8'h00, 8'h00, 1'b1, 1'b1);
`ifdef VRF_REQ_PERF_EN
        n_vec++;
        assert (stall_conflict_cnt_o === 32'd1) else begin
            n_err++;
            $error("FAIL t3_conflict_cnt observed=%0d expected=1", stall_conflict_cnt_o);
        end
`endif

        // Write bank 2 and read bank 3 in the same cycle
        cmd_valid_i = 1'b1; cmd_addr_i = 16'd3; cmd_len_i = 8'd1; cmd_opqueue_i = OPQ_ALU_A;
        expect_next("t4_accept", 8'h00, 8'h00, 1'b0, 1'b0);
        cmd_valid_i = 1'b0;
        wr_valid_i = 1'b1; wr_addr_i = 16'd2; wr_data_i = 64'h0011_2233_4455_6677; wr_be_i = 8'h0F;
        expect_next("t4_both", 8'h0C, 8'h04, 1'b0, 1'b0, 2, 16'd0, OPQ_ALU_A,
                    64'h0011_2233_4455_6677, 8'h0F);
        wr_valid_i = 1'b0;
        expect_next("t4_done", 8'h00, 8'h00, 1'b1, 1'b1);

        // len=0: no reads, done two cycles after accept
        cmd_valid_i = 1'b1; cmd_addr_i = 16'd7; cmd_len_i = 8'd0;
        expect_next("t5_accept", 8'h00, 8'h00, 1'b0, 1'b0);
        cmd_valid_i = 1'b0;
        expect_next("t5_done", 8'h00, 8'h00, 1'b1, 1'b1);
        expect_next("t5_idle", 8'h00, 8'h00, 1'b0, 1'b1);

        // Reset after 2 of 6 reads, then a wrapping command sees full credits
        cmd_valid_i = 1'b1; cmd_addr_i = 16'h0010; cmd_len_i = 8'd6; cmd_opqueue_i = OPQ_ALU_B;
        expect_next("t6_accept", 8'h00, 8'h00, 1'b0, 1'b0);
        cmd_valid_i = 1'b0;
        expect_next("t6_r0", 8'h01, 8'h00, 1'b0, 1'b0, 0, 16'd2, OPQ_ALU_B);
        expect_next("t6_r1", 8'h02, 8'h00, 1'b0, 1'b0, 1, 16'd2, OPQ_ALU_B);
        rst_i = 1'b1;
        expect_next("t6_reset", 8'h00, 8'h00, 1'b0, 1'b0);
        rst_i = 1'b0;
        expect_next("t6_idle", 8'h00, 8'h00, 1'b0, 1'b1);
        cmd_valid_i = 1'b1; cmd_addr_i = 16'hFFFE; cmd_len_i = 8'd6; cmd_opqueue_i = OPQ_MFPU;
        expect_next("t6b_accept", 8'h00, 8'h00, 1'b0, 1'b0);
        cmd_valid_i = 1'b0;
        expect_next("t6b_w0", 8'h40, 8'h00, 1'b0, 1'b0, 6, 16'h1FFF, OPQ_MFPU);
        expect_next("t6b_w1", 8'h80, 8'h00, 1'b0, 1'b0, 7, 16'h1FFF, OPQ_MFPU);
        expect_next("t6b_w2", 8'h01, 8'h00, 1'b0, 1'b0, 0, 16'h0000, OPQ_MFPU);
        expect_next("t6b_w3", 8'h02, 8'h00, 1'b0, 1'b0, 1, 16'h0000, OPQ_MFPU);
        repeat (2) expect_next("t6b_stall", 8'h00, 8'h00, 1'b0, 1'b0);
        rst_i = 1'b1;
        expect_next("final_reset", 8'h00, 8'h00, 1'b0, 1'b0);
        rst_i = 1'b0;
        expect_next("final_idle", 8'h00, 8'h00, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
